// File: rtl/ps2_digit_entry.sv
// PS/2 keyboard digit-entry controller: frame receiver, scan-code decoder and a
// BCD entry buffer that hands the committed number over with a held-valid/ack handshake.
module ps2_digit_entry #(
    parameter int NUM_DIGITS     = 3,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic                            CLK,
    input  logic                            reset,
    input  logic                            PS2_CLK,
    input  logic                            PS2_DATA,
    input  logic                            iNumAck,
    output logic [4*NUM_DIGITS-1:0]         oDigits,
    output logic [$clog2(NUM_DIGITS+1)-1:0] oCount,
    output logic                            oNumRdy,
    output logic                            oErr,
    output logic [2:0]                      oLED
);
    localparam int CW  = $clog2(NUM_DIGITS+1);
    localparam int WDW = $clog2(TIMEOUT_CYCLES+1);

    typedef enum logic {RX_IDLE, RX_BUSY} rx_state_t;
    typedef enum logic {ENTRY, HOLD} entry_state_t;
    typedef enum logic [2:0] {K_NONE, K_DIGIT, K_BKSP, K_ESC, K_ENTER} key_kind_t;
    typedef struct packed {
        key_kind_t  kind;
        logic [3:0] digit;
    } key_t;

    function automatic key_t decode_key(input logic [7:0] code, input logic ext);
        key_t k;
        k.kind  = K_NONE;
        k.digit = 4'd0;
        if (ext) begin
            if (code == 8'h5A) k.kind = K_ENTER;
        end else begin
            k.kind = K_DIGIT;
            case (code)
                8'h45, 8'h70: k.digit = 4'd0;
                8'h16, 8'h69: k.digit = 4'd1;
                8'h1E, 8'h72: k.digit = 4'd2;
                8'h26, 8'h7A: k.digit = 4'd3;
                8'h25, 8'h6B: k.digit = 4'd4;
                8'h2E, 8'h73: k.digit = 4'd5;
                8'h36, 8'h74: k.digit = 4'd6;
                8'h3D, 8'h6C: k.digit = 4'd7;
                8'h3E, 8'h75: k.digit = 4'd8;
                8'h46, 8'h7D: k.digit = 4'd9;
                8'h66:        k.kind  = K_BKSP;
                8'h76:        k.kind  = K_ESC;
                8'h5A:        k.kind  = K_ENTER;
                default:      k.kind  = K_NONE;
            endcase
        end
        return k;
    endfunction

    // p0: synchronised pins, registered falling-edge strobe and the data bit under it
    logic [SYNC_STAGES-1:0] clk_sync, data_sync;
    logic                   clk_last, fall_p0, bit_p0;

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            clk_sync  <= '1;
            data_sync <= '1;
            clk_last  <= 1'b1;
            fall_p0   <= 1'b0;
            bit_p0    <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], PS2_CLK};
            data_sync <= {data_sync[SYNC_STAGES-2:0], PS2_DATA};
            clk_last  <= clk_sync[SYNC_STAGES-1];
            fall_p0   <= clk_last & ~clk_sync[SYNC_STAGES-1];
            bit_p0    <= data_sync[SYNC_STAGES-1];
        end
    end

    rx_state_t      rx_state, rx_next;
    logic [3:0]     bit_cnt;
    logic [7:0]     shreg, byte_p1;
    logic           parity_bit, frame_end, timeout, byte_ok, rx_err;
    logic [WDW-1:0] wd_cnt;
    logic           vld_p1, frame_err_p1;

    assign frame_end = (rx_state == RX_BUSY) && fall_p0 && (bit_cnt == 4'd10);
    assign timeout   = (rx_state == RX_BUSY) && !fall_p0 && (wd_cnt == WDW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) rx_state <= RX_IDLE;
        else        rx_state <= rx_next;
    end

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            RX_IDLE: if (fall_p0 && !bit_p0)   rx_next = RX_BUSY;
            RX_BUSY: if (frame_end || timeout) rx_next = RX_IDLE;
            default:                           rx_next = RX_IDLE;
        endcase
    end

    always_comb begin
        byte_ok = frame_end && bit_p0 && (^{shreg, parity_bit});
        rx_err  = (frame_end && !byte_ok) || timeout;
    end

    // p1: assembled byte and frame-error strobe; bit_cnt 1..8 data, 9 parity, 10 stop
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            bit_cnt      <= 4'd1;
            shreg        <= 8'd0;
            parity_bit   <= 1'b0;
            wd_cnt       <= '0;
            vld_p1       <= 1'b0;
            frame_err_p1 <= 1'b0;
            byte_p1      <= 8'd0;
        end else begin
            vld_p1       <= byte_ok;
            frame_err_p1 <= rx_err;
            if (byte_ok) byte_p1 <= shreg;
            if (rx_state == RX_IDLE) begin
                bit_cnt <= 4'd1;
                wd_cnt  <= '0;
            end else if (fall_p0) begin
                bit_cnt <= bit_cnt + 4'd1;
                wd_cnt  <= '0;
                if (bit_cnt <= 4'd8)      shreg      <= {bit_p0, shreg[7:1]};
                else if (bit_cnt == 4'd9) parity_bit <= bit_p0;
            end else begin
                wd_cnt <= wd_cnt + 1'b1;
            end
        end
    end

    logic brk, ext, is_prefix, key_evt;
    key_t key;

    assign is_prefix = (byte_p1 == 8'hE0) || (byte_p1 == 8'hF0);
    assign key_evt   = vld_p1 && !is_prefix && brk;
    assign key       = decode_key(byte_p1, ext);

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            brk <= 1'b0;
            ext <= 1'b0;
        end else if (vld_p1) begin
            if (byte_p1 == 8'hE0)      ext <= 1'b1;
            else if (byte_p1 == 8'hF0) brk <= 1'b1;
            else begin
                brk <= 1'b0;
                ext <= 1'b0;
            end
        end
    end

    entry_state_t            state, state_next;
    logic [4*NUM_DIGITS-1:0] digits_next;
    logic [CW-1:0]           count_next;
    logic                    entry_err, take_ack;

    assign take_ack = (state == HOLD) && iNumAck;

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) state <= ENTRY;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ENTRY:   if (key_evt && key.kind == K_ENTER && oCount != '0) state_next = HOLD;
            HOLD:    if (iNumAck) state_next = ENTRY;
            default: state_next = ENTRY;
        endcase
    end

    // The ack outranks a coincident key event; HOLD freezes the buffer otherwise
    always_comb begin
        digits_next = oDigits;
        count_next  = oCount;
        entry_err   = 1'b0;
        if (take_ack) begin
            digits_next = '0;
            count_next  = '0;
        end else if (state == ENTRY && key_evt) begin
            case (key.kind)
                K_DIGIT: begin
                    if (oCount < CW'(NUM_DIGITS)) begin
                        for (int i = 0; i < NUM_DIGITS; i++)
                            if (CW'(i) == oCount) digits_next[i*4 +: 4] = key.digit;
                        count_next = oCount + CW'(1);
                    end else begin
                        entry_err = 1'b1;
                    end
                end
                K_BKSP: begin
                    if (oCount != '0) begin
                        for (int i = 0; i < NUM_DIGITS; i++)
                            if (CW'(i + 1) == oCount) digits_next[i*4 +: 4] = 4'd0;
                        count_next = oCount - CW'(1);
                    end
                end
                K_ESC: begin
                    digits_next = '0;
                    count_next  = '0;
                end
                K_ENTER: if (oCount == '0) entry_err = 1'b1;
                default: ;
            endcase
        end
    end

    // p2: registered outputs
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            oDigits <= '0;
            oCount  <= '0;
            oErr    <= 1'b0;
        end else begin
            oDigits <= digits_next;
            oCount  <= count_next;
            oErr    <= frame_err_p1 | entry_err;
        end
    end

    assign oNumRdy = (state == HOLD);

    always_comb begin
        oLED[0] = (oCount != '0) && (state == ENTRY);
        oLED[1] = (oCount == CW'(NUM_DIGITS));
        oLED[2] = (state == HOLD);
    end
endmodule

// File: tb/tb_ps2_digit_entry.sv
// Scoreboard bench for ps2_digit_entry: byte-level keyboard model predicts every
// visible output change; a negedge monitor pops and compares.
module tb_ps2_digit_entry;
    localparam int ND = 3;

    logic        CLK = 1'b0;
    logic        reset = 1'b0;
    logic        PS2_CLK = 1'b1;
    logic        PS2_DATA = 1'b1;
    logic        iNumAck = 1'b0;
    logic [11:0] oDigits;
    logic [1:0]  oCount;
    logic        oNumRdy, oErr;
    logic [2:0]  oLED;

    ps2_digit_entry #(.NUM_DIGITS(ND), .TIMEOUT_CYCLES(200), .SYNC_STAGES(2)) dut (
        .CLK(CLK), .reset(reset), .PS2_CLK(PS2_CLK), .PS2_DATA(PS2_DATA),
        .iNumAck(iNumAck), .oDigits(oDigits), .oCount(oCount),
        .oNumRdy(oNumRdy), .oErr(oErr), .oLED(oLED)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string       tag;
        bit          err;
        logic [11:0] dig;
        int          cnt;
        bit          rdy;
    } exp_t;

    exp_t  sb[$];
    int    n_checks = 0;
    int    n_pass = 0;
    string cur_tag = "init";

    int m_dig[ND];
    int m_cnt = 0;
    bit m_hold = 0, m_brk = 0, m_ext = 0;

    logic [7:0] top_row [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    logic [7:0] keypad  [10] = '{8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B, 8'h73, 8'h74, 8'h6C, 8'h75, 8'h7D};

    // kind: 0 none, 1 digit, 2 backspace, 3 escape, 4 enter
    function automatic int key_kind(input logic [7:0] c, input bit ext, output int d);
        d = 0;
        if (ext) return (c == 8'h5A) ? 4 : 0;
        for (int i = 0; i < 10; i++)
            if (c == top_row[i] || c == keypad[i]) begin
                d = i;
                return 1;
            end
        if (c == 8'h66) return 2;
        if (c == 8'h76) return 3;
        if (c == 8'h5A) return 4;
        return 0;
    endfunction

    function automatic void expect_now(bit err);
        exp_t e;
        e.tag = cur_tag;
        e.err = err;
        e.dig = '0;
        for (int i = 0; i < ND; i++) e.dig[i*4 +: 4] = 4'(m_dig[i]);
        e.cnt = m_cnt;
        e.rdy = m_hold;
        sb.push_back(e);
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < ND; i++) m_dig[i] = 0;
        m_cnt = 0;
    endfunction

    function automatic void model_key(int kind, int d);
        if (m_hold) return;
        case (kind)
            1: if (m_cnt < ND) begin m_dig[m_cnt] = d; m_cnt++; expect_now(0); end
               else expect_now(1);
            2: if (m_cnt > 0) begin m_cnt--; m_dig[m_cnt] = 0; expect_now(0); end
            3: if (m_cnt > 0) begin model_clear(); expect_now(0); end
            4: if (m_cnt > 0) begin m_hold = 1; expect_now(0); end
               else expect_now(1);
            default: ;
        endcase
    endfunction

    function automatic void model_byte(logic [7:0] b, bit ack);
        bit evt = 0;
        int kind = 0, d = 0;
        if (b == 8'hE0) m_ext = 1;
        else if (b == 8'hF0) m_brk = 1;
        else begin
            evt  = m_brk;
            kind = key_kind(b, m_ext, d);
            m_brk = 0;
            m_ext = 0;
        end
        if (ack && m_hold) begin
            m_hold = 0;
            model_clear();
            expect_now(0);
        end else if (evt) begin
            model_key(kind, d);
        end
    endfunction

    task automatic send_bit(input logic b, input bit ack_it);
        PS2_DATA = b;
        repeat (2) @(posedge CLK);
        #1 PS2_CLK = 1'b0;
        repeat (4) @(posedge CLK);
        #1 if (ack_it) iNumAck = 1'b1;
        @(posedge CLK);
        #1 iNumAck = 1'b0;
        @(posedge CLK);
        #1 PS2_CLK = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop, input bit ack);
        logic [10:0] bits;
        if (bad_par || bad_stop) expect_now(1);
        else model_byte(b, ack);
        bits[0]    = 1'b0;
        bits[8:1]  = b;
        bits[9]    = ~(^b) ^ bad_par;
        bits[10]   = ~bad_stop;
        for (int i = 0; i < 11; i++) send_bit(bits[i], ack && (i == 10));
    endtask

    task automatic press(input logic [7:0] c);
        send_frame(c, 0, 0, 0);
        send_frame(8'hF0, 0, 0, 0);
        send_frame(c, 0, 0, 0);
    endtask

    task automatic press_ext(input logic [7:0] c);
        send_frame(8'hE0, 0, 0, 0);
        send_frame(c, 0, 0, 0);
        send_frame(8'hE0, 0, 0, 0);
        send_frame(8'hF0, 0, 0, 0);
        send_frame(c, 0, 0, 0);
    endtask

    task automatic do_ack();
        if (m_hold) begin
            m_hold = 0;
            model_clear();
            expect_now(0);
        end
        @(posedge CLK);
        #1 iNumAck = 1'b1;
        @(posedge CLK);
        #1 iNumAck = 1'b0;
        repeat (2) @(posedge CLK);
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    // Monitor: every visible change (or error pulse) must match the next expected record
    initial begin
        logic [11:0] pd;
        logic [1:0]  pc;
        logic        pr;
        logic [2:0]  eled;
        exp_t        e;
        pd = '0;
        pc = '0;
        pr = 1'b0;
        forever begin
            @(negedge CLK);
            if (oErr || oDigits !== pd || oCount !== pc || oNumRdy !== pr) begin
                n_checks++;
                if (sb.size() == 0) begin
                    $display("FAIL unexpected_output: err=%0b dig=%h cnt=%0d rdy=%0b, want no change",
                             oErr, oDigits, oCount, oNumRdy);
                end else begin
                    e = sb.pop_front();
                    eled = {e.rdy, e.cnt == ND, (e.cnt > 0) && !e.rdy};
                    if (oErr === e.err && oDigits === e.dig && oCount === 2'(e.cnt) &&
                        oNumRdy === e.rdy && oLED === eled)
                        n_pass++;
                    else
                        $display("FAIL %s: got err=%0b dig=%h cnt=%0d rdy=%0b led=%b, want err=%0b dig=%h cnt=%0d rdy=%0b led=%b",
                                 e.tag, oErr, oDigits, oCount, oNumRdy, oLED,
                                 e.err, e.dig, e.cnt, e.rdy, eled);
                end
            end
            pd = oDigits;
            pc = oCount;
            pr = oNumRdy;
        end
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: simulation did not finish, want completion");
        $fatal(1, "time limit exceeded");
    end

    initial begin
        for (int i = 0; i < ND; i++) m_dig[i] = 0;
        repeat (5) @(posedge CLK);
        #1;
        check("reset_digits", int'(oDigits), 0);
        check("reset_count", int'(oCount), 0);
        check("reset_rdy", int'(oNumRdy), 0);
        check("reset_err", int'(oErr), 0);
        check("reset_led", int'(oLED), 0);
        reset = 1'b1;
        repeat (3) @(posedge CLK);

        cur_tag = "enter_321";
        press(8'h16); press(8'h1E); press(8'h26); press(8'h5A);
        repeat (20) @(posedge CLK);
        #1;
        check("hold_rdy", int'(oNumRdy), 1);
        check("hold_digits", int'(oDigits), 'h321);
        check("hold_count", int'(oCount), 3);
        cur_tag = "ack_321";
        do_ack();

        cur_tag = "edit_074";
        press(8'h25); press(8'h2E); press(8'h66); press(8'h6C); press_ext(8'h5A);
        #1;
        check("edit_digits", int'(oDigits), 'h074);
        check("edit_rdy", int'(oNumRdy), 1);
        cur_tag = "ack_074";
        do_ack();

        cur_tag = "bad_parity";
        send_frame(8'h16, 1, 0, 0);
        cur_tag = "good_after_parity";
        send_frame(8'h16, 0, 0, 0);
        send_frame(8'hF0, 0, 0, 0);
        send_frame(8'h16, 0, 0, 0);

        cur_tag = "overflow_and_empty_enter";
        press(8'h1E); press(8'h26); press(8'h25);
        press(8'h76); press(8'h5A);
        #1;
        check("empty_count", int'(oCount), 0);
        check("empty_rdy", int'(oNumRdy), 0);

        cur_tag = "timeout";
        expect_now(1);
        send_bit(1'b0, 0);
        for (int i = 0; i < 4; i++) send_bit(1'($urandom_range(0, 1)), 0);
        repeat (300) @(posedge CLK);
        cur_tag = "after_timeout";
        send_frame(8'hF0, 0, 0, 0);
        send_frame(8'h45, 0, 0, 0);
        #1;
        check("timeout_digit0", int'(oDigits[3:0]), 0);
        check("timeout_count", int'(oCount), 1);

        cur_tag = "hold_ignore";
        press(8'h3E); press(8'h5A);
        press(8'h46);
        #1;
        check("frozen_digits", int'(oDigits), 'h080);
        check("frozen_count", int'(oCount), 2);
        cur_tag = "ack_with_key";
        send_frame(8'h3D, 0, 0, 0);
        send_frame(8'hF0, 0, 0, 0);
        send_frame(8'h3D, 0, 0, 1);
        #1;
        check("ack_key_count", int'(oCount), 0);
        check("ack_key_rdy", int'(oNumRdy), 0);

        cur_tag = "random";
        for (int n = 0; n < 80; n++) begin
            int r;
            int idx;
            r = $urandom_range(0, 19);
            idx = $urandom_range(0, 9);
            if (m_hold && r < 8) do_ack();
            else if (r < 10) begin
                if ($urandom_range(0, 1) == 1) press(top_row[idx]);
                else press(keypad[idx]);
            end
            else if (r < 12) press(8'h66);
            else if (r == 12) press(8'h76);
            else if (r < 15) begin
                if ($urandom_range(0, 1) == 1) press(8'h5A);
                else press_ext(8'h5A);
            end
            else if (r < 17) send_frame(8'($urandom_range(0, 255)), r == 15, r == 16, 0);
            else if (r == 17) press_ext(8'($urandom_range(0, 255)));
            else send_frame(8'($urandom_range(0, 255)), 0, 0, 0);
        end

        cur_tag = "pre_reset";
        send_frame(8'h00, 0, 0, 0);
        if (m_hold) do_ack();
        press(8'h2E);
        send_bit(1'b0, 0);
        send_bit(1'b1, 0);
        send_bit(1'b1, 0);
        cur_tag = "async_reset";
        model_clear();
        m_hold = 0;
        m_brk = 0;
        m_ext = 0;
        expect_now(0);
        @(posedge CLK);
        #3 reset = 1'b0;
        #1;
        check("rst_digits", int'(oDigits), 0);
        check("rst_count", int'(oCount), 0);
        check("rst_rdy", int'(oNumRdy), 0);
        check("rst_led", int'(oLED), 0);
        repeat (3) @(posedge CLK);
        #1 reset = 1'b1;
        repeat (3) @(posedge CLK);
        cur_tag = "after_reset";
        press(8'h16);
        #1;
        check("post_rst_digits", int'(oDigits), 1);
        check("post_rst_count", int'(oCount), 1);

        repeat (20) @(posedge CLK);
        check("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
